gowin_sp: RTL and testbench

- Single-port synchronous block RAM: one clock, one address bus, shared read/write.
- Behaviour matches the Gowin SP BSRAM primitive.
- Holds the 2048 x 16 instruction store.
- During boot, a loader fills the store over the write path; after boot, the cpu fetches instructions through dout with oce tied high.

---
 rtl/gowin_sp.sv | 91 +++++++++
 tb/tb_gowin_sp.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gowin_sp.sv
// Single-port synchronous block RAM that behaves like the Gowin SP BSRAM primitive.
// Optional per-byte write enables are compiled in when the macro SP_BYTE_WE_EN is defined.
module gowin_sp #(
  parameter int              ADDR_W     = 11,
  parameter int              DATA_W     = 16,
  parameter int              READ_MODE  = 0,
  parameter int              WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter string           INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
`ifdef SP_BYTE_WE_EN
  input  logic [DATA_W/8-1:0] byte_we,
`endif
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NB-1:0]     byteEn;
  logic [DATA_W-1:0] oldWord;
  logic [DATA_W-1:0] mergedWord;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] out_q, out_d;

  // Power-up contents: zero everywhere.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

`ifdef SP_BYTE_WE_EN
  assign byteEn = byte_we;
`else
  assign byteEn = '1;
`endif

  assign oldWord = mem[ad];

  always_comb begin
    mergedWord = oldWord;
    for (int b = 0; b < NB; b++) begin
      if (byteEn[b]) mergedWord[b*8 +: 8] = din[b*8 +: 8];
    end
  end

  // A write with no byte lanes enabled still counts as a write cycle for rd_q.
  always_comb begin
    rd_d = rd_q;
    if (ce) begin
      if (!wre) begin
        rd_d = oldWord;
      end else if (WRITE_MODE == 1) begin
        rd_d = mergedWord;
      end else if (WRITE_MODE == 2) begin
        rd_d = oldWord;
      end
    end
  end

  assign out_d = oce ? rd_q : out_q;

  always_ff @(posedge clk) begin
    if (ce && wre) begin
      for (int b = 0; b < NB; b++) begin
        if (byteEn[b]) mem[ad][b*8 +: 8] <= din[b*8 +: 8];
      end
    end
  end

  // Reset only touches the output path; the array keeps its contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= RESET_VAL;
      out_q <= RESET_VAL;
    end else begin
      rd_q  <= rd_d;
      out_q <= out_d;
    end
  end

  assign dout = (READ_MODE == 1) ? out_q : rd_q;

endmodule

// File: tb/tb_gowin_sp.sv
// Self-checking bench for gowin_sp: three instances (bypass/normal, bypass/write-through,
// pipeline/read-before-write) share one stimulus stream and are checked against a word-level model.
module tb_gowin_sp;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        oce;
  logic        wre;
  logic [10:0] ad;
  logic [15:0] din;
  logic [1:0]  byteWe;
  logic [15:0] dout0, dout1, dout2;

  int compared;
  int mismatched;

  logic [15:0] refMem [2048];
  logic [15:0] rdModel [3];
  logic [15:0] outModel;
  logic [15:0] expDout [3];
  logic [15:0] doutArr [3];

  assign doutArr[0] = dout0;
  assign doutArr[1] = dout1;
  assign doutArr[2] = dout2;

  gowin_sp #(.READ_MODE(0), .WRITE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
`ifdef SP_BYTE_WE_EN
    .byte_we(byteWe),
`endif
    .dout(dout0)
  );

  gowin_sp #(.READ_MODE(0), .WRITE_MODE(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
`ifdef SP_BYTE_WE_EN
    .byte_we(byteWe),
`endif
    .dout(dout1)
  );

  gowin_sp #(.READ_MODE(1), .WRITE_MODE(2)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
`ifdef SP_BYTE_WE_EN
    .byte_we(byteWe),
`endif
    .dout(dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mergeWord(input logic [15:0] old, input logic [15:0] d,
                                            input logic [1:0] be);
`ifdef SP_BYTE_WE_EN
    mergeWord = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
`else
    mergeWord = d;
`endif
  endfunction

  task automatic refreshExpected();
    expDout[0] = rdModel[0];
    expDout[1] = rdModel[1];
    expDout[2] = outModel;
  endtask

  // Drive one access, advance one edge, update the model, and settle 1 time unit past the edge.
  task automatic applyCycle(input logic c, input logic w, input logic o, input logic [10:0] a,
                            input logic [15:0] d, input logic [1:0] be);
    logic [15:0] old, mg, prevRd2;
    ce = c; wre = w; oce = o; ad = a; din = d; byteWe = be;
    @(posedge clk);
    old     = refMem[a];
    mg      = mergeWord(old, d, be);
    prevRd2 = rdModel[2];
    if (c) begin
      if (w) begin
        refMem[a]  = mg;
        rdModel[1] = mg;
        rdModel[2] = old;
      end else begin
        for (int m = 0; m < 3; m++) rdModel[m] = old;
      end
    end
    if (o) outModel = prevRd2;
    refreshExpected();
    #1;
  endtask

  task automatic modelReset();
    for (int m = 0; m < 3; m++) rdModel[m] = 16'h0000;
    outModel = 16'h0000;
    refreshExpected();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (doutArr[k] !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL reset_initial dut%0d: got %h expected %h", k, doutArr[k], 16'h0000);
      end
    end
    applyCycle(1, 1, 1, 11'd5, 16'hBEEF, 2'b11);
    applyCycle(1, 0, 1, 11'd5, 16'h0000, 2'b11);
    applyCycle(0, 0, 1, 11'd5, 16'h0000, 2'b11);
    compared++;
    if (dout2 !== 16'hBEEF) begin
      mismatched++;
      $display("[TB] FAIL reset_preload dut2: got %h expected %h", dout2, 16'hBEEF);
    end
    #1 reset = 1'b1;
    #1;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (doutArr[k] !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL reset_async dut%0d: got %h expected %h", k, doutArr[k], 16'h0000);
      end
    end
    #1 reset = 1'b0;
    applyCycle(1, 0, 1, 11'd5, 16'h0000, 2'b11);
    compared++;
    if (dout0 !== 16'hBEEF) begin
      mismatched++;
      $display("[TB] FAIL reset_mem_kept dut0: got %h expected %h", dout0, 16'hBEEF);
    end
  endtask

  task automatic test_boot_fill();
    logic [15:0] img [3];
    img[0] = 16'h00A1; img[1] = 16'h0078; img[2] = 16'h0066;
    for (int i = 0; i < 3; i++) applyCycle(1, 1, 1, 11'(i), img[i], 2'b11);
    for (int i = 0; i < 3; i++) begin
      applyCycle(1, 0, 1, 11'(i), 16'h0000, 2'b11);
      compared++;
      if (dout0 !== img[i]) begin
        mismatched++;
        $display("[TB] FAIL boot_read addr %0d: got %h expected %h", i, dout0, img[i]);
      end
      for (int k = 1; k < 3; k++) begin
        compared++;
        if (doutArr[k] !== expDout[k]) begin
          mismatched++;
          $display("[TB] FAIL boot_model dut%0d: got %h expected %h", k, doutArr[k], expDout[k]);
        end
      end
    end
  endtask

  task automatic test_write_modes();
    applyCycle(1, 1, 1, 11'd7, 16'h1111, 2'b11);
    applyCycle(1, 0, 1, 11'd0, 16'h0000, 2'b11);
    applyCycle(1, 1, 1, 11'd7, 16'h2222, 2'b11);
    compared++;
    if (dout0 !== 16'h00A1) begin
      mismatched++;
      $display("[TB] FAIL wmode_normal: got %h expected %h", dout0, 16'h00A1);
    end
    compared++;
    if (dout1 !== 16'h2222) begin
      mismatched++;
      $display("[TB] FAIL wmode_through: got %h expected %h", dout1, 16'h2222);
    end
    applyCycle(0, 0, 1, 11'd7, 16'h0000, 2'b11);
    compared++;
    if (dout2 !== 16'h1111) begin
      mismatched++;
      $display("[TB] FAIL wmode_rbw: got %h expected %h", dout2, 16'h1111);
    end
    applyCycle(1, 0, 1, 11'd7, 16'h0000, 2'b11);
    compared++;
    if (dout0 !== 16'h2222) begin
      mismatched++;
      $display("[TB] FAIL wmode_readback: got %h expected %h", dout0, 16'h2222);
    end
  endtask

  task automatic test_ce_gating();
    applyCycle(1, 1, 1, 11'd3, 16'h0055, 2'b11);
    applyCycle(1, 0, 1, 11'd3, 16'h0000, 2'b11);
    applyCycle(0, 1, 1, 11'd4, 16'hFFFF, 2'b11);
    compared++;
    if (dout0 !== 16'h0055) begin
      mismatched++;
      $display("[TB] FAIL ce_hold: got %h expected %h", dout0, 16'h0055);
    end
    applyCycle(1, 0, 1, 11'd4, 16'h0000, 2'b11);
    compared++;
    if (dout0 !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL ce_mem_kept: got %h expected %h", dout0, 16'h0000);
    end
  endtask

  task automatic test_pipeline();
    applyCycle(1, 0, 1, 11'd1, 16'h0000, 2'b11);
    compared++;
    if (dout2 === 16'h0078) begin
      mismatched++;
      $display("[TB] FAIL pipe_early: got %h expected not %h", dout2, 16'h0078);
    end
    applyCycle(0, 0, 1, 11'd1, 16'h0000, 2'b11);
    compared++;
    if (dout2 !== 16'h0078) begin
      mismatched++;
      $display("[TB] FAIL pipe_second_edge: got %h expected %h", dout2, 16'h0078);
    end
    applyCycle(1, 0, 1, 11'd2, 16'h0000, 2'b11);
    applyCycle(0, 0, 0, 11'd2, 16'h0000, 2'b11);
    compared++;
    if (dout2 !== 16'h0078) begin
      mismatched++;
      $display("[TB] FAIL pipe_oce_hold: got %h expected %h", dout2, 16'h0078);
    end
    applyCycle(0, 0, 0, 11'd2, 16'h0000, 2'b11);
    applyCycle(0, 0, 1, 11'd2, 16'h0000, 2'b11);
    compared++;
    if (dout2 !== 16'h0066) begin
      mismatched++;
      $display("[TB] FAIL pipe_oce_release: got %h expected %h", dout2, 16'h0066);
    end
  endtask

  task automatic test_addr_edges();
    applyCycle(1, 1, 1, 11'd2047, 16'h7E57, 2'b11);
    applyCycle(1, 0, 1, 11'd2047, 16'h0000, 2'b11);
    compared++;
    if (dout0 !== 16'h7E57) begin
      mismatched++;
      $display("[TB] FAIL addr_top: got %h expected %h", dout0, 16'h7E57);
    end
    applyCycle(1, 0, 1, 11'd0, 16'h0000, 2'b11);
    compared++;
    if (dout0 !== 16'h00A1) begin
      mismatched++;
      $display("[TB] FAIL addr_zero: got %h expected %h", dout0, 16'h00A1);
    end
  endtask

`ifdef SP_BYTE_WE_EN
  task automatic test_byte_we();
    applyCycle(1, 1, 1, 11'd9, 16'hABCD, 2'b11);
    applyCycle(1, 1, 1, 11'd9, 16'h1234, 2'b01);
    compared++;
    if (dout1 !== 16'hAB34) begin
      mismatched++;
      $display("[TB] FAIL bwe_through: got %h expected %h", dout1, 16'hAB34);
    end
    applyCycle(1, 1, 1, 11'd9, 16'h5678, 2'b00);
    applyCycle(1, 0, 1, 11'd9, 16'h0000, 2'b11);
    compared++;
    if (dout0 !== 16'hAB34) begin
      mismatched++;
      $display("[TB] FAIL bwe_merge: got %h expected %h", dout0, 16'hAB34);
    end
  endtask
`endif

  task automatic test_random();
    logic [10:0] a;
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      applyCycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) != 0), a, 16'($urandom), 2'($urandom));
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (doutArr[k] !== expDout[k]) begin
          mismatched++;
          $display("[TB] FAIL random dut%0d cycle %0d: got %h expected %h",
                   k, n, doutArr[k], expDout[k]);
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 2048; i++) refMem[i] = 16'h0000;
    modelReset();
    reset = 1'b1; ce = 1'b0; oce = 1'b0; wre = 1'b0; ad = '0; din = '0; byteWe = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    test_reset();
    test_boot_fill();
    test_write_modes();
    test_ce_gating();
    test_pipeline();
    test_addr_edges();
`ifdef SP_BYTE_WE_EN
    test_byte_we();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
